// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_ctrl_pkg : state codes, opcode constants and control encodings for the
//               multi-cycle MIPS-subset control sequencer.   Rev 1.0
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLT   = 6'h06;
  localparam logic [5:0] OP_BLE   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_RFN = 3'd2;
  localparam logic [2:0] ALU_ORI = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BLE  = 3'd4;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [2:0] branch_type;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic [2:0] branch_type_of(input logic [5:0] op);
    logic [2:0] bt;
    bt = BR_NONE;
    case (op)
      OP_BEQ:  bt = BR_BEQ;
      OP_BNE:  bt = BR_BNE;
      OP_BLT:  bt = BR_BLT;
      OP_BLE:  bt = BR_BLE;
      default: bt = BR_NONE;
    endcase
    return bt;
  endfunction

  // A store retires on the cycle memory accepts it; every other last step retires unconditionally.
  function automatic logic is_retiring(input state_t s, input logic mem_ready);
    logic r;
    r = 1'b0;
    case (s)
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR: r = 1'b1;
      S_MEM_WR: r = mem_ready;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_control_fsm_if : opcode/memory handshake inputs and control-word outputs
//                     between sequencer (master) and datapath (slave).  Rev 1.0
// ----------------------------------------------------------------------------
interface mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       instr_op_i;
  logic [5:0]       funct_i;
  logic             mem_ready_i;
  logic             PC_write_o;
  logic             PC_write_cond_o;
  logic [2:0]       BranchType_o;
  logic [1:0]       PCSrc_o;
  logic             IorD_o;
  logic             MemRead_o;
  logic             MemWrite_o;
  logic             IR_write_o;
  logic             RegWrite_o;
  logic [1:0]       RegDst_o;
  logic [1:0]       MemtoReg_o;
  logic             ALUSrcA_o;
  logic [1:0]       ALUSrcB_o;
  logic [2:0]       ALU_op_o;
  logic             illegal_o;
  logic [CNT_W-1:0] instr_count_o;
  logic [3:0]       state_o;

  modport master (
    input  instr_op_i, funct_i, mem_ready_i,
    output PC_write_o, PC_write_cond_o, BranchType_o, PCSrc_o, IorD_o,
           MemRead_o, MemWrite_o, IR_write_o, RegWrite_o, RegDst_o,
           MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o, illegal_o,
           instr_count_o, state_o
  );

  modport slave (
    output instr_op_i, funct_i, mem_ready_i,
    input  PC_write_o, PC_write_cond_o, BranchType_o, PCSrc_o, IorD_o,
           MemRead_o, MemWrite_o, IR_write_o, RegWrite_o, RegDst_o,
           MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o, illegal_o,
           instr_count_o, state_o
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_ctrl_outdec : combinational state + opcode to control-word decoder.
//                  Rev 1.0
// ----------------------------------------------------------------------------
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o             = '0;
    ctrl_o.branch_type = BR_NONE;
    ctrl_o.pc_src      = PCSRC_ALU;
    ctrl_o.reg_dst     = REGDST_RT;
    ctrl_o.mem_to_reg  = M2R_ALUOUT;
    ctrl_o.alu_src_b   = SRCB_RT;
    ctrl_o.alu_op      = ALU_ADD;

    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        // IR and PC only move on the cycle the instruction word actually arrives.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_RFN;
      end
      S_WB_R: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RD;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        case (instr_op_i)
          OP_ORI:  ctrl_o.alu_op = ALU_ORI;
          OP_LUI:  ctrl_o.alu_op = ALU_LUI;
          default: ctrl_o.alu_op = ALU_ADD;
        endcase
      end
      S_WB_I: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PCSRC_ALUOUT;
        ctrl_o.branch_type   = branch_type_of(instr_op_i);
        ctrl_o.alu_op        = ((instr_op_i == OP_BEQ) || (instr_op_i == OP_BNE)) ?
                               ALU_SUB : ALU_SLT;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_JUMP;
      end
      S_JAL: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PCSRC_JUMP;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RA;
        ctrl_o.mem_to_reg = M2R_PC;
      end
      S_JR: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_RS;
      end
      S_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_control_fsm : multi-cycle control sequencer -- state register, dispatch,
//                  memory-wait handling and retired-instruction counter. Rev 1.0
// ----------------------------------------------------------------------------
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int PC_INC = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mc_control_fsm_if.master bus
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctrl_word_t       ctrl;

  // The FETCH constant select (ALUSrcB=1) is fixed in the datapath; no other step exists here.
  if (PC_INC != 4) begin : g_pc_inc_fixed
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;

    case (state_q)
      S_FETCH:    if (bus.mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.instr_op_i)
          OP_RTYPE:                       state_d = (bus.funct_i == FN_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI:        state_d = S_EXEC_I;
          OP_LW, OP_SW:                   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BLT, OP_BLE: state_d = S_BRANCH;
          OP_J:                           state_d = S_JUMP;
          OP_JAL:                         state_d = S_JAL;
          default:                        state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (bus.instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready_i) state_d = S_WB_MEM;
      S_MEM_WR:   if (bus.mem_ready_i) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH,
      S_JUMP, S_JAL, S_JR, S_TRAP:
                  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase

    if (is_retiring(state_q, bus.mem_ready_i)) count_d = count_q + C_CNT_ONE;
  end

  mc_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .instr_op_i  (bus.instr_op_i),
    .mem_ready_i (bus.mem_ready_i),
    .ctrl_o      (ctrl)
  );

  assign bus.PC_write_o      = ctrl.pc_write;
  assign bus.PC_write_cond_o = ctrl.pc_write_cond;
  assign bus.BranchType_o    = ctrl.branch_type;
  assign bus.PCSrc_o         = ctrl.pc_src;
  assign bus.IorD_o          = ctrl.iord;
  assign bus.MemRead_o       = ctrl.mem_read;
  assign bus.MemWrite_o      = ctrl.mem_write;
  assign bus.IR_write_o      = ctrl.ir_write;
  assign bus.RegWrite_o      = ctrl.reg_write;
  assign bus.RegDst_o        = ctrl.reg_dst;
  assign bus.MemtoReg_o      = ctrl.mem_to_reg;
  assign bus.ALUSrcA_o       = ctrl.alu_src_a;
  assign bus.ALUSrcB_o       = ctrl.alu_src_b;
  assign bus.ALU_op_o        = ctrl.alu_op;
  assign bus.illegal_o       = ctrl.illegal;
  assign bus.instr_count_o   = count_q;
  assign bus.state_o         = state_q;

endmodule
`default_nettype wire
